// File: rtl/stream_demux_pkg.sv
// ----------------------------------------------------------------------------
// stream_demux_pkg : shared types and constants for the stream demultiplexer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/stream_demux_oreg.sv
// ----------------------------------------------------------------------------
// stream_demux_oreg : one-entry valid/ready output register (data + last)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_demux_oreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // Loads are only issued while o_can_load is high, so a stalled entry is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = ~r_valid | i_ready;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux : registered 1-to-CH_NUM packet demux with valid/ready on all sides
// Optional per-channel delivery counters: define STREAM_DEMUX_STATS_EN
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(CH_NUM)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     s_valid_in,
  output logic                     s_ready_out,
  input  logic [DATA_W-1:0]        s_data_in,
  input  logic [SEL_W-1:0]         s_sel_in,
  input  logic                     s_last_in,
  output logic [CH_NUM-1:0]        m_valid_out,
  input  logic [CH_NUM-1:0]        m_ready_in,
  output logic [CH_NUM*DATA_W-1:0] m_data_out,
  output logic [CH_NUM-1:0]        m_last_out,
  output logic                     err_out,
  output logic                     busy_out
`ifdef STREAM_DEMUX_STATS_EN
  ,
  input  logic                     stat_clr_in,
  output logic [CH_NUM*STAT_W-1:0] stat_cnt_out
`endif
);

  localparam logic [SEL_W:0] c_ch_num = CH_NUM[SEL_W:0];

  state_e           r_state;
  logic [SEL_W-1:0] r_route;
  logic             r_err;
  logic             r_busy;

  logic              w_sel_legal;
  logic              w_drop_mode;
  logic              w_ch_ready;
  logic              w_accept;
  logic [SEL_W-1:0]  w_tgt;
  logic [CH_NUM-1:0] w_tgt_hot;
  logic [CH_NUM-1:0] w_oreg_ready;
  logic [CH_NUM-1:0] w_load;

  assign w_sel_legal = ({1'b0, s_sel_in} < c_ch_num);
  assign w_tgt       = (r_state == ROUTE) ? r_route : s_sel_in;
  // Dropped beats never touch an output register, so they are always accepted.
  assign w_drop_mode = (r_state == DROP) || ((r_state == IDLE) && !w_sel_legal);
  assign w_ch_ready  = |(w_tgt_hot & w_oreg_ready);
  assign s_ready_out = w_drop_mode | w_ch_ready;
  assign w_accept    = s_valid_in & s_ready_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_route <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            r_route <= s_sel_in;
            if (!w_sel_legal) begin
              r_err <= 1'b1;
              if (!s_last_in) begin
                r_state <= DROP;
                r_busy  <= 1'b1;
              end
            end else if (!s_last_in) begin
              r_state <= ROUTE;
              r_busy  <= 1'b1;
            end
          end
          ROUTE, DROP: begin
            if (s_last_in) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign err_out  = r_err;
  assign busy_out = r_busy;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign w_tgt_hot[k] = (w_tgt == SEL_W'(k));
    assign w_load[k]    = w_accept & ~w_drop_mode & w_tgt_hot[k];

    stream_demux_oreg #(
      .DATA_W (DATA_W)
    ) u_oreg (
      .clk        (clk_in),
      .rst_n      (rst_n_in),
      .i_load     (w_load[k]),
      .i_data     (s_data_in),
      .i_last     (s_last_in),
      .i_ready    (m_ready_in[k]),
      .o_valid    (m_valid_out[k]),
      .o_data     (m_data_out[k*DATA_W +: DATA_W]),
      .o_last     (m_last_out[k]),
      .o_can_load (w_oreg_ready[k])
    );
  end

`ifdef STREAM_DEMUX_STATS_EN
  for (genvar k = 0; k < CH_NUM; k++) begin : g_stat
    logic [STAT_W-1:0] r_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_cnt <= '0;
      end else if (stat_clr_in) begin
        r_cnt <= '0;
      end else if (m_valid_out[k] && m_ready_in[k] && (r_cnt != STAT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign stat_cnt_out[k*STAT_W +: STAT_W] = r_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ----------------------------------------------------------------------------
// tb_stream_demux : drives a 4-channel and a 3-channel demux from shared stimulus
// and checks both against a packet/queue reference model. Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stream_demux;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       s_valid;
  logic [7:0] s_data;
  logic [1:0] s_sel;
  logic       s_last;
  logic [3:0] m_ready;
  logic       stat_clr;

  logic        u4_sr, u4_err, u4_busy;
  logic [3:0]  u4_mv, u4_ml;
  logic [31:0] u4_md;
  logic        u3_sr, u3_err, u3_busy;
  logic [2:0]  u3_mv, u3_ml;
  logic [23:0] u3_md;
`ifdef STREAM_DEMUX_STATS_EN
  logic [63:0] u4_st;
  logic [47:0] u3_st;
`endif

  always #5 clk_in = ~clk_in;

  stream_demux #(.CH_NUM(4), .DATA_W(8)) u_dut4 (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .s_valid_in  (s_valid),
    .s_ready_out (u4_sr),
    .s_data_in   (s_data),
    .s_sel_in    (s_sel),
    .s_last_in   (s_last),
    .m_valid_out (u4_mv),
    .m_ready_in  (m_ready),
    .m_data_out  (u4_md),
    .m_last_out  (u4_ml),
    .err_out     (u4_err),
    .busy_out    (u4_busy)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .stat_clr_in (stat_clr),
    .stat_cnt_out(u4_st)
`endif
  );

  stream_demux #(.CH_NUM(3), .DATA_W(8)) u_dut3 (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .s_valid_in  (s_valid),
    .s_ready_out (u3_sr),
    .s_data_in   (s_data),
    .s_sel_in    (s_sel),
    .s_last_in   (s_last),
    .m_valid_out (u3_mv),
    .m_ready_in  (m_ready[2:0]),
    .m_data_out  (u3_md),
    .m_last_out  (u3_ml),
    .err_out     (u3_err),
    .busy_out    (u3_busy)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .stat_clr_in (stat_clr),
    .stat_cnt_out(u3_st)
`endif
  );

  logic [3:0]  mv [2];
  logic [3:0]  ml [2];
  logic [31:0] md [2];
  logic        sr [2];
  logic        er [2];
  logic        bz [2];
  logic [63:0] st [2];
  assign mv[0] = u4_mv;  assign mv[1] = {1'b0, u3_mv};
  assign ml[0] = u4_ml;  assign ml[1] = {1'b0, u3_ml};
  assign md[0] = u4_md;  assign md[1] = {8'h00, u3_md};
  assign sr[0] = u4_sr;  assign sr[1] = u3_sr;
  assign er[0] = u4_err; assign er[1] = u3_err;
  assign bz[0] = u4_busy; assign bz[1] = u3_busy;
`ifdef STREAM_DEMUX_STATS_EN
  assign st[0] = u4_st;  assign st[1] = {16'h0000, u3_st};
`else
  assign st[0] = '0;     assign st[1] = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-channel queues of beats accepted but not yet delivered.
  logic [8:0]  q [2][4][$];
  bit          in_pkt [2];
  bit          drop   [2];
  bit          err_pend [2];
  int          dest [2];
  int          nch  [2];
  int unsigned cnt  [2][4];
  bit          exp_rdy [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input int d);
    int k;
    if (in_pkt[d] ? drop[d] : (int'(s_sel) >= nch[d])) return 1'b1;
    k = in_pkt[d] ? dest[d] : int'(s_sel);
    return (q[d][k].size() == 0) || m_ready[k];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      in_pkt[d] = 0; drop[d] = 0; err_pend[d] = 0; dest[d] = 0;
      for (int k = 0; k < 4; k++) begin
        q[d][k].delete();
        cnt[d][k] = 0;
      end
    end
  endtask

  task automatic model_edge(input int d);
    bit acc;
    bit new_err;
    acc = s_valid && exp_rdy[d];
    new_err = 0;
    for (int k = 0; k < nch[d]; k++) begin
      if (stat_clr) cnt[d][k] = 0;
      else if (q[d][k].size() > 0 && m_ready[k] && cnt[d][k] < 32'hFFFF) cnt[d][k]++;
      if (q[d][k].size() > 0 && m_ready[k]) void'(q[d][k].pop_front());
    end
    if (acc) begin
      if (!in_pkt[d]) begin
        if (int'(s_sel) >= nch[d]) begin
          new_err = 1;
          if (!s_last) begin in_pkt[d] = 1; drop[d] = 1; end
        end else begin
          q[d][s_sel].push_back({s_last, s_data});
          if (!s_last) begin in_pkt[d] = 1; drop[d] = 0; dest[d] = int'(s_sel); end
        end
      end else begin
        if (!drop[d]) q[d][dest[d]].push_back({s_last, s_data});
        if (s_last) in_pkt[d] = 0;
      end
    end
    err_pend[d] = new_err;
  endtask

  // Check every observable output against the model, then advance one clock.
  task automatic cyc();
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = model_ready(d);
      chk($sformatf("d%0d s_ready", d), 64'(sr[d]), 64'(exp_rdy[d]));
      chk($sformatf("d%0d err", d), 64'(er[d]), 64'(err_pend[d]));
      chk($sformatf("d%0d busy", d), 64'(bz[d]), 64'(in_pkt[d]));
      for (int k = 0; k < nch[d]; k++) begin
        chk($sformatf("d%0d ch%0d valid", d, k), 64'(mv[d][k]), 64'(q[d][k].size() > 0));
        if (q[d][k].size() > 0) begin
          chk($sformatf("d%0d ch%0d data", d, k), 64'(md[d][k*8 +: 8]), 64'(q[d][k][0][7:0]));
          chk($sformatf("d%0d ch%0d last", d, k), 64'(ml[d][k]), 64'(q[d][k][0][8]));
        end
`ifdef STREAM_DEMUX_STATS_EN
        chk($sformatf("d%0d ch%0d stat", d, k), 64'(st[d][k*16 +: 16]), 64'(cnt[d][k]));
`endif
      end
    end
    @(posedge clk_in);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk_in);
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d valid", tag, d), 64'(mv[d]), 64'h0);
      chk($sformatf("%s d%0d data", tag, d), 64'(md[d]), 64'h0);
      chk($sformatf("%s d%0d last", tag, d), 64'(ml[d]), 64'h0);
      chk($sformatf("%s d%0d err", tag, d), 64'(er[d]), 64'h0);
      chk($sformatf("%s d%0d busy", tag, d), 64'(bz[d]), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
      chk($sformatf("%s d%0d stat", tag, d), st[d], 64'h0);
`endif
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] sel, input logic [7:0] data, input bit last);
    s_valid = v; s_sel = sel; s_data = data; s_last = last;
  endtask

  initial begin
    nch[0] = 4; nch[1] = 3;
    model_reset();
    rst_n_in = 1'b0; stat_clr = 1'b0; m_ready = 4'hF;
    drive(0, 2'd0, 8'h00, 0);
    repeat (2) @(negedge clk_in);
    chk_reset("reset");
    rst_n_in = 1'b1;

    // 3-beat packet to channel 2; select changes after the first beat are ignored
    drive(1, 2'd2, 8'hA1, 0); cyc();
    chk("t1 beat1 valid", 64'(u4_mv), 64'h4);
    chk("t1 beat1 data", 64'(u4_md[23:16]), 64'hA1);
    chk("t1 busy open", 64'(u4_busy), 64'h1);
    drive(1, 2'd0, 8'hA2, 0); cyc();
    drive(1, 2'd0, 8'hA3, 1); cyc();
    chk("t1 beat3 valid", 64'(u4_mv), 64'h4);
    chk("t1 beat3 data", 64'(u4_md[23:16]), 64'hA3);
    chk("t1 beat3 last", 64'(u4_ml), 64'h4);
    chk("t1 busy closed", 64'(u4_busy), 64'h0);
    drive(0, 2'd0, 8'h00, 0); cyc();

    // Channel 1 stalled while channel 0 keeps flowing
    m_ready = 4'b1101;
    drive(1, 2'd1, 8'h11, 1); cyc();
    drive(1, 2'd1, 8'h22, 1);
    #1 chk("t2 blocked ready", 64'(u4_sr), 64'h0);
    cyc(); cyc();
    chk("t2 ch1 hold data", 64'(u4_md[15:8]), 64'h11);
    drive(1, 2'd0, 8'h33, 1); cyc();
    chk("t2 ch0 data", 64'(u4_md[7:0]), 64'h33);
    chk("t2 ch1 still held", 64'(u4_md[15:8]), 64'h11);
    drive(0, 2'd0, 8'h00, 0); cyc();
    m_ready = 4'hF; cyc(); cyc();

    // Illegal select on the 3-channel instance: dropped, one err pulse
    drive(1, 2'd3, 8'h55, 0); cyc();
    chk("t3 err pulse", 64'(u3_err), 64'h1);
    chk("t3 no valid", 64'(u3_mv), 64'h0);
    drive(1, 2'd3, 8'h56, 1);
    #1 chk("t3 drop ready", 64'(u3_sr), 64'h1);
    cyc();
    chk("t3 err once", 64'(u3_err), 64'h0);
    chk("t3 idle again", 64'(u3_busy), 64'h0);
    drive(0, 2'd0, 8'h00, 0); cyc();

    // Full-throughput 8-beat packet to channel 3
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'd3, 8'h80 + 8'(i), i == 7);
      #1 chk("t4 ready high", 64'(u4_sr), 64'h1);
      cyc();
      chk("t4 ch3 valid", 64'(u4_mv[3]), 64'h1);
      chk("t4 ch3 data", 64'(u4_md[31:24]), 64'(8'h80 + 8'(i)));
    end
    drive(0, 2'd0, 8'h00, 0); cyc();

    // Asynchronous reset in the middle of a packet
    m_ready = 4'h0;
    drive(1, 2'd2, 8'hC1, 0); cyc();
    drive(1, 2'd2, 8'hC2, 0);
    #2 rst_n_in = 1'b0;
    #1 chk_reset("midrst");
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_ready = 4'hF;
    drive(1, 2'd1, 8'h77, 1); cyc();
    chk("t5 ch1 valid", 64'(u4_mv), 64'h2);
    chk("t5 ch1 data", 64'(u4_md[15:8]), 64'h77);
    drive(0, 2'd0, 8'h00, 0); cyc();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
      m_ready = 4'($urandom);
      cyc();
    end
    // Close any open packet and drain
    m_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin drive(1, 2'd0, 8'hEE, 1); cyc(); end
    drive(0, 2'd0, 8'h00, 0); cyc(); cyc();

`ifdef STREAM_DEMUX_STATS_EN
    stat_clr = 1'b1; cyc(); stat_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(1, 2'd0, 8'(i), i == 4); cyc(); end
    drive(0, 2'd0, 8'h00, 0); cyc(); cyc();
    chk("stat five", 64'(u4_st[15:0]), 64'd5);
    stat_clr = 1'b1; cyc(); stat_clr = 1'b0;
    chk("stat cleared", 64'(u4_st[15:0]), 64'd0);
    for (int i = 0; i < 2; i++) begin drive(1, 2'd0, 8'(i), i == 1); cyc(); end
    drive(0, 2'd0, 8'h00, 0); cyc(); cyc();
    chk("stat two", 64'(u4_st[15:0]), 64'd2);
    for (int i = 0; i < 65534; i++) begin drive(1, 2'd0, 8'(i), 1); cyc(); end
    drive(0, 2'd0, 8'h00, 0); cyc(); cyc();
    chk("stat saturated", 64'(u4_st[15:0]), 64'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised 1-to-CH_NUM stream demultiplexer with a valid/ready handshake on every side.
- Registered successor to the combinational 1x4 demux. It routes whole packets to one output channel, holding the route from the first beat to the last.
- Each output has a one-entry register, so an output stalled by backpressure does not corrupt data on any other channel.
- Sits between a single producer and CH_NUM downstream consumers in the datapath.

Parameters:
- CH_NUM, 4, number of output channels (2..16).
- DATA_W, 8, payload width in bits.
- SEL_W, $clog2(CH_NUM), select width. Derived; do not override.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- s_valid_in  input  1  input beat valid.
- s_ready_out  output  1  input beat accepted when s_valid_in and s_ready_out are both high.
- s_data_in  input  DATA_W  input payload.
- s_sel_in  input  SEL_W  destination channel; sampled on the first beat of a packet only.
- s_last_in  input  1  final beat of the packet.
- m_valid_out  output  CH_NUM  per-channel valid.
- m_ready_in  input  CH_NUM  per-channel ready.
- m_data_out  output  CH_NUM*DATA_W  channel k payload in bits [k*DATA_W +: DATA_W].
- m_last_out  output  CH_NUM  per-channel last flag.
- err_out  output  1  one-cycle pulse when a packet is dropped for an illegal select.
- busy_out  output  1  high while a packet is open (state ROUTE or DROP).

Behaviour:
- Reset, asynchronous: m_valid_out=0, m_data_out=0, m_last_out=0, err_out=0, busy_out=0, FSM=IDLE, route register=0.
- FSM states and transitions:
  - IDLE: the first accepted beat latches s_sel_in into the route register.
    - Legal select, s_last_in=0 -> ROUTE.
    - Legal select, s_last_in=1 -> stay IDLE (single-beat packet).
  - ROUTE: s_sel_in is ignored. Beats go to the latched channel. The accepted beat with s_last_in=1 -> IDLE.
  - DROP: entered when the first beat has s_sel_in >= CH_NUM and s_last_in=0.
    - Beats are accepted with s_ready_out=1 and discarded.
    - The accepted beat with s_last_in=1 -> IDLE.
- Illegal select:
  - err_out pulses on the cycle after the first beat is accepted. It pulses exactly once per dropped packet.
  - A single-beat illegal packet stays in IDLE and still pulses err_out.
  - Only reachable when CH_NUM is not a power of 2.
- Ready:
  - Target channel k is s_sel_in in IDLE, or the route register in ROUTE.
  - s_ready_out = !m_valid_out[k] | m_ready_in[k] for channel k.
  - In DROP, s_ready_out = 1.
  - In IDLE with an illegal s_sel_in, s_ready_out = 1.
- Latency: an accepted beat appears on m_*_out[k] on the next cycle. Full throughput is one beat per cycle with a continuous consumer.
- Output register k:
  - Loads on accept. Holds data, last and valid stable while m_valid_out[k]=1 and m_ready_in[k]=0.
  - Clears valid on m_ready_in[k]=1 with no new load.
  - A simultaneous drain and load keeps valid=1 and takes the new data.
- Other channels: their registers are never written. They drain independently and concurrently.
- s_valid_in=0: no state change; outputs drain only.
- Reset mid-packet: all in-flight beats are discarded, FSM returns to IDLE, and the next beat is treated as a first beat.

Optional Feature:
- Macro: STREAM_DEMUX_STATS_EN.
- When defined:
  - Adds output stat_cnt_out, width CH_NUM*16: per-channel count of beats delivered, i.e. output handshakes.
  - Counters saturate at 16'hFFFF.
  - Adds input stat_clr_in, 1 bit: synchronous clear of all counters. Clear has priority over increment in the same cycle.
  - Counters reset to 0.
- When undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package stream_demux_pkg holds:
  - the FSM state enum (IDLE, ROUTE, DROP);
  - localparams STAT_W=16 and STAT_MAX=16'hFFFF.
- Sub-module stream_demux_oreg: one-entry valid/ready register carrying data and last. It is instantiated CH_NUM times in a generate loop.

Test Plan:
- Reset, then s_sel_in=2, 3-beat packet with data 8'hA1,8'hA2,8'hA3 and last on beat 3; s_sel_in toggled to 0 during beats 2-3 -> all three beats appear on channel 2 only, one cycle after accept; busy_out goes 1 then 0 after beat 3.
- Channel 1 holds m_ready_in=0 while single-beat packets go to channel 1 and then channel 0 -> channel 1 holds 8'h11 stable; s_ready_out=0 for the second channel-1 packet; the channel-0 packet passes unaffected.
- CH_NUM=3, 2-beat packet with s_sel_in=3 -> both beats accepted, no m_valid_out asserted, err_out high for exactly one cycle, FSM returns to IDLE.
- Continuous 8-beat packet to channel 3 with m_ready_in all 1 -> s_ready_out stays 1, and 8 consecutive m_valid_out[3] cycles carry the data in order.
- Assert rst_n_in low mid-packet between clock edges -> outputs clear immediately; a packet sent after reset with s_sel_in=1 routes to channel 1.
- With STREAM_DEMUX_STATS_EN: send 5 beats to channel 0, pulse stat_clr_in, then send 2 beats -> counter reads 5 before the clear and 2 after; preload a counter to 16'hFFFF and deliver one more beat -> it stays 16'hFFFF.
